// File: rtl/bitwise_logic_pipe.sv
// bitwise_logic_pipe: configurable two-operand bitwise operation with an
// output XOR mask, carried through a STAGES-deep valid/ready pipeline.
// Every accepted operand pair carries its own op/mask snapshot, so
// configuration writes never disturb items already in flight. A saturating
// counter records completed output handshakes for debug readback.
module bitwise_logic_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             cfg_we,
    input  logic [2:0]       cfg_op,
    input  logic [WIDTH-1:0] cfg_mask,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic [CNT_W-1:0] xfer_count
);

    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_mask;

    logic             r_vld_p0;
    logic [WIDTH-1:0] r_a_p0;
    logic [WIDTH-1:0] r_b_p0;
    logic [2:0]       r_op_p0;
    logic [WIDTH-1:0] r_mask_p0;
    logic [WIDTH-1:0] w_res_p0;

    logic             w_en;
    logic             w_out_vld;
    logic [WIDTH-1:0] w_out_dat;
    logic             w_tail_busy;
    logic [CNT_W-1:0] r_cnt;

    function automatic logic [WIDTH-1:0] apply_op(input logic [2:0] op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        case (op)
            3'd0:    return ~a;
            3'd1:    return a;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return ~(a & b);
            3'd6:    return ~(a | b);
            default: return ~(a ^ b);
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    // The whole pipeline moves together; it stalls only when the output
    // slot holds a result the consumer has not taken.
    assign w_en     = !(w_out_vld && !out_ready);
    assign in_ready = w_en;

    // Configuration registers; writes land regardless of pipeline stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op   <= 3'd0;
            r_mask <= '0;
        end else if (cfg_we) begin
            r_op   <= cfg_op;
            r_mask <= cfg_mask;
        end
    end

    // ---- stage 0: capture operands with the op/mask in force before any
    // same-edge configuration write ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p0  <= 1'b0;
            r_a_p0    <= '0;
            r_b_p0    <= '0;
            r_op_p0   <= 3'd0;
            r_mask_p0 <= '0;
        end else if (w_en) begin
            r_vld_p0  <= in_valid;
            r_a_p0    <= in_a;
            r_b_p0    <= in_b;
            r_op_p0   <= r_op;
            r_mask_p0 <= r_mask;
        end
    end

    // Invalid slots carry zero so out_data reads 0 for bubbles and after reset.
    assign w_res_p0 = r_vld_p0 ? (apply_op(r_op_p0, r_a_p0, r_b_p0) ^ r_mask_p0) : '0;

    // ---- stages 1..STAGES-1: shift valid and result toward the output ----
    generate
        if (STAGES == 1) begin : g_single
            assign w_out_vld   = r_vld_p0;
            assign w_out_dat   = w_res_p0;
            assign w_tail_busy = 1'b0;
        end else begin : g_tail
            logic             r_vld_pk [1:STAGES-1];
            logic [WIDTH-1:0] r_res_pk [1:STAGES-1];

            // Result shift register; all stages hold together when stalled.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int k = 1; k < STAGES; k++) begin
                        r_vld_pk[k] <= 1'b0;
                        r_res_pk[k] <= '0;
                    end
                end else if (w_en) begin
                    r_vld_pk[1] <= r_vld_p0;
                    r_res_pk[1] <= w_res_p0;
                    for (int k = 2; k < STAGES; k++) begin
                        r_vld_pk[k] <= r_vld_pk[k-1];
                        r_res_pk[k] <= r_res_pk[k-1];
                    end
                end
            end

            // Any valid slot beyond stage 0 keeps the block busy.
            always_comb begin
                w_tail_busy = 1'b0;
                for (int k = 1; k < STAGES; k++) begin
                    w_tail_busy = w_tail_busy | r_vld_pk[k];
                end
            end

            assign w_out_vld = r_vld_pk[STAGES-1];
            assign w_out_dat = r_res_pk[STAGES-1];
        end
    endgenerate

    // ---- output side: count completed handshakes, saturating ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_out_vld && out_ready) begin
            r_cnt <= sat_inc(r_cnt);
        end
    end

    assign out_valid  = w_out_vld;
    assign out_data   = w_out_dat;
    assign busy       = r_vld_p0 | w_tail_busy;
    assign xfer_count = r_cnt;

endmodule
